// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcodes and alu_op codes for the multi-cycle control unit
package multicycle_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_SVPC = 4'b1111;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_BRN  = 4'b1010;
  localparam logic [3:0] OP_JM   = 4'b1011;

  localparam logic [2:0] ALU_NONE  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_INC   = 3'b010;
  localparam logic [2:0] ALU_NEG   = 3'b011;
  localparam logic [2:0] ALU_PCIMM = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;

  // Per-op control vector; to_mem/to_wb select the phase that follows EXEC/MEM.
  typedef struct packed {
    logic alu_src;
    logic pc_control;
    logic jump;
    logic brz;
    logic brn;
    logic to_mem;
    logic to_wb;
    logic mem_rd;
    logic mem_wr;
    logic jm;
    logic wb_mtr;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_control_op_decoder.sv
// rtl/multicycle_control_op_decoder.sv - combinational opcode to per-phase control vector
import multicycle_pkg::*;

module multicycle_control_op_decoder #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] op,
  output logic [ALUOP_W-1:0]  alu_op,
  output dec_t                dec
);

  logic [2:0] aop;

  always_comb begin
    dec = '0;
    aop = ALU_NONE;
    if ((op >> 4) != '0) begin
      dec.illegal = 1'b1;
    end else begin
      case (op[3:0])
        OP_NOP: ;
        OP_SVPC: begin
          dec.alu_src = 1'b1; aop = ALU_PCIMM; dec.pc_control = 1'b1;
          dec.to_wb = 1'b1; dec.wb_mtr = 1'b1;
        end
        OP_LD: begin
          dec.alu_src = 1'b1; aop = ALU_ADD; dec.to_mem = 1'b1;
          dec.mem_rd = 1'b1; dec.to_wb = 1'b1; dec.wb_mtr = 1'b1;
        end
        OP_ST: begin
          dec.alu_src = 1'b1; aop = ALU_ADD; dec.to_mem = 1'b1; dec.mem_wr = 1'b1;
        end
        OP_JM: begin
          dec.alu_src = 1'b1; aop = ALU_ADD; dec.to_mem = 1'b1;
          dec.mem_rd = 1'b1; dec.jm = 1'b1;
        end
        OP_ADD: begin aop = ALU_ADD; dec.to_wb = 1'b1; end
        OP_INC: begin aop = ALU_INC; dec.to_wb = 1'b1; end
        OP_NEG: begin aop = ALU_NEG; dec.to_wb = 1'b1; end
        OP_SUB: begin aop = ALU_SUB; dec.to_wb = 1'b1; end
        OP_J:   dec.jump = 1'b1;
        OP_BRZ: dec.brz = 1'b1;
        OP_BRN: dec.brn = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(aop);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer driving registered datapath controls
import multicycle_pkg::*;

module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                z_flag,
  input  logic                n_flag,
  output logic                fetch_en,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_control,
  output logic                branch,
  output logic                mem_to_reg,
  output logic                jump,
  output logic                reg_write,
  output logic                jump_m,
  output logic                illegal_op,
  output logic                instr_done
);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] dec_op;
  logic [ALUOP_W-1:0]  dec_alu_op;
  dec_t                dec;

  // DECODE looks at the live IR opcode so illegal_op can flag it in that phase.
  assign dec_op = (state == DECODE) ? opcode : op_q;

  multicycle_control_op_decoder #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) u_op_decoder (
    .op    (dec_op),
    .alu_op(dec_alu_op),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    fetch_en   <= 1'b0;
    ir_load    <= 1'b0;
    pc_inc     <= 1'b0;
    alu_src    <= 1'b0;
    alu_op     <= '0;
    mem_read   <= 1'b0;
    mem_write  <= 1'b0;
    pc_control <= 1'b0;
    branch     <= 1'b0;
    mem_to_reg <= 1'b0;
    jump       <= 1'b0;
    reg_write  <= 1'b0;
    jump_m     <= 1'b0;
    illegal_op <= 1'b0;
    instr_done <= 1'b0;
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      case (state)
        FETCH: begin
          fetch_en <= 1'b1;
          if (mem_ready) begin
            ir_load <= 1'b1;
            pc_inc  <= 1'b1;
            state   <= DECODE;
          end
        end
        DECODE: begin
          op_q       <= opcode;
          illegal_op <= dec.illegal;
          state      <= EXEC;
        end
        EXEC: begin
          alu_src    <= dec.alu_src;
          alu_op     <= dec_alu_op;
          pc_control <= dec.pc_control;
          jump       <= dec.jump;
          branch     <= (dec.brz & z_flag) | (dec.brn & n_flag);
          if (dec.to_mem) begin
            state <= MEM;
          end else if (dec.to_wb) begin
            state <= WB;
          end else begin
            instr_done <= 1'b1;
            state      <= FETCH;
          end
        end
        MEM: begin
          mem_read  <= dec.mem_rd;
          mem_write <= dec.mem_wr;
          if (mem_ready) begin
            if (dec.to_wb) begin
              state <= WB;
            end else begin
              jump_m     <= dec.jm;
              instr_done <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        WB: begin
          reg_write  <= 1'b1;
          mem_to_reg <= dec.wb_mtr;
          instr_done <= 1'b1;
          state      <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized trace-based check of multicycle_control against per-instruction expectations
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'b0;
  logic       mem_ready = 1'b0;
  logic       z_flag = 1'b0;
  logic       n_flag = 1'b0;

  logic       fetch_en, ir_load, pc_inc, alu_src;
  logic [2:0] alu_op;
  logic       mem_read, mem_write, pc_control, branch, mem_to_reg;
  logic       jump, reg_write, jump_m, illegal_op, instr_done;

  multicycle_control #(.OPCODE_W(4), .ALUOP_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .z_flag(z_flag), .n_flag(n_flag),
    .fetch_en(fetch_en), .ir_load(ir_load), .pc_inc(pc_inc), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .pc_control(pc_control), .branch(branch), .mem_to_reg(mem_to_reg),
    .jump(jump), .reg_write(reg_write), .jump_m(jump_m),
    .illegal_op(illegal_op), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  localparam int B_DONE = 0,  B_ILL = 1,  B_JM = 2,   B_RW = 3,   B_JMP = 4,  B_MTR = 5;
  localparam int B_BR = 6,    B_PCC = 7,  B_MW = 8,   B_MR = 9,   B_ALU = 10, B_SRC = 13;
  localparam int B_PCI = 14,  B_IRL = 15, B_FET = 16;

  logic [16:0] obs;
  assign obs = {fetch_en, ir_load, pc_inc, alu_src, alu_op, mem_read, mem_write,
                pc_control, branch, mem_to_reg, jump, reg_write, jump_m, illegal_op, instr_done};

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  logic [3:0]  opc_q[$];
  logic        rdy_q[$], z_q[$], n_q[$];

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %05h want %05h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [16:0] bitv(input int b);
    return 17'(1) << b;
  endfunction

  task automatic push(input logic [16:0] e, input logic [3:0] opc, input logic rdy,
                      input logic z, input logic n);
    exp_q.push_back(e); opc_q.push_back(opc); rdy_q.push_back(rdy);
    z_q.push_back(z); n_q.push_back(n);
  endtask

  // Expected output per cycle for one instruction, from the instruction's phase rules.
  task automatic build_instr(input logic [3:0] op, input int fw, input int mw,
                             input logic zf, input logic nf);
    logic is_alu, is_svpc, is_ld, is_st, is_jm, is_mem, to_wb, legal;
    logic [2:0]  aop;
    logic [16:0] e, rw;
    is_alu  = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
    is_svpc = (op == 4'b1111);
    is_ld   = (op == 4'b1110);
    is_st   = (op == 4'b0011);
    is_jm   = (op == 4'b1011);
    is_mem  = is_ld || is_st || is_jm;
    to_wb   = is_alu || is_svpc || is_ld;
    legal   = is_alu || is_svpc || is_mem || (op == 4'b0000) ||
              (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
    case (op)
      4'b0100: aop = 3'd1;
      4'b0101: aop = 3'd2;
      4'b0110: aop = 3'd3;
      4'b0111: aop = 3'd5;
      4'b1111: aop = 3'd4;
      4'b1110, 4'b0011, 4'b1011: aop = 3'd1;
      default: aop = 3'd0;
    endcase
    for (int i = 0; i < fw; i++)
      push(bitv(B_FET), 4'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    push(bitv(B_FET) | bitv(B_IRL) | bitv(B_PCI), 4'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    push(legal ? 17'd0 : bitv(B_ILL), op, 1'($urandom), 1'($urandom), 1'($urandom));
    e = {14'd0, aop} << B_ALU;
    if (is_svpc || is_mem) e |= bitv(B_SRC);
    if (is_svpc) e |= bitv(B_PCC);
    if (op == 4'b1000) e |= bitv(B_JMP);
    if ((op == 4'b1001 && zf) || (op == 4'b1010 && nf)) e |= bitv(B_BR);
    if (!is_mem && !to_wb) e |= bitv(B_DONE);
    push(e, 4'($urandom), 1'($urandom), zf, nf);
    if (is_mem) begin
      rw = is_st ? bitv(B_MW) : bitv(B_MR);
      for (int i = 0; i < mw; i++)
        push(rw, 4'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      e = rw;
      if (is_jm) e |= bitv(B_JM);
      if (!is_ld) e |= bitv(B_DONE);
      push(e, 4'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    end
    if (to_wb) begin
      e = bitv(B_RW) | bitv(B_DONE);
      if (is_ld || is_svpc) e |= bitv(B_MTR);
      push(e, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic run(input string tag, input int n);
    int k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      opcode    = opc_q.pop_front();
      mem_ready = rdy_q.pop_front();
      z_flag    = z_q.pop_front();
      n_flag    = n_q.pop_front();
      @(posedge clk); #1;
      check(tag, obs, exp_q.pop_front());
      k++;
    end
    exp_q.delete(); opc_q.delete(); rdy_q.delete(); z_q.delete(); n_q.delete();
  endtask

  logic [3:0] op_tbl[16];

  initial begin
    for (int i = 0; i < 16; i++) op_tbl[i] = 4'(i);

    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", obs, 17'd0);
    reset = 1'b0;

    build_instr(4'b0100, 0, 0, 1'b0, 1'b0); run("add", -1);
    build_instr(4'b1110, 0, 2, 1'b0, 1'b0); run("ld_wait", -1);
    build_instr(4'b1001, 0, 0, 1'b1, 1'b0); run("brz_taken", -1);
    build_instr(4'b1001, 0, 0, 1'b0, 1'b1); run("brz_not", -1);
    build_instr(4'b1111, 1, 0, 1'b0, 1'b0); run("svpc", -1);
    build_instr(4'b1100, 0, 0, 1'b1, 1'b1); run("illegal", -1);
    build_instr(4'b1011, 0, 1, 1'b0, 1'b0); run("jm", -1);

    build_instr(4'b0011, 0, 3, 1'b0, 1'b0); run("st_pre_rst", 5);
    mem_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("st_mid_rst", obs, 17'd0);
    reset = 1'b0;
    build_instr(4'b0100, 0, 0, 1'b0, 1'b0); run("after_rst", -1);

    for (int t = 0; t < 200; t++) begin
      build_instr(op_tbl[$urandom_range(15)], $urandom_range(2), $urandom_range(2),
                  1'($urandom), 1'($urandom));
      run("rnd", -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing control unit for the accumulator-style datapath. It replaces the single-cycle opcode decoder with a parametrised FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Memory phases wait on a ready handshake, and branch conditions are resolved from ALU flags. It sits between instruction memory/IR and the datapath, and drives every datapath mux/enable from flops.

## Interface
- OPCODE_W, 4: opcode field width; opcodes wider than 4 bits with any upper bit set decode as illegal.
- ALUOP_W, 3: ALU operation select width; minimum 3.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  instruction opcode from IR, sampled only in DECODE
- mem_ready  in  1  memory completes the current fetch/read/write this cycle
- z_flag, n_flag  in  1 each  ALU zero/negative flags, sampled in EXEC
- fetch_en  out  1  instruction fetch request
- ir_load  out  1  load IR, one-cycle pulse
- pc_inc  out  1  PC ← PC+1, one-cycle pulse
- alu_src, alu_op[ALUOP_W], mem_read, mem_write, pc_control, branch, mem_to_reg, jump, reg_write, jump_m  out  datapath controls
- illegal_op  out  1  pulse: unknown opcode decoded
- instr_done  out  1  pulse: last cycle of an instruction

## Operation
- Opcodes (4-bit):
  - 0000 NOP
  - 1111 SVPC
  - 1110 LD
  - 0011 ST
  - 0100 ADD
  - 0101 INC
  - 0110 NEG
  - 0111 SUB
  - 1000 J
  - 1001 BRZ
  - 1010 BRN
  - 1011 JM
  - All others: illegal, executed as NOP.
- alu_op codes: 000 none, 001 ADD, 010 INC, 011 NEG, 100 PC+imm, 101 SUB.
- States: FETCH → DECODE → EXEC → {MEM | WB | FETCH}.
- FETCH:
  - fetch_en=1; hold until mem_ready.
  - On mem_ready: ir_load=1, pc_inc=1, go to DECODE.
- DECODE: latch opcode into internal op register; no datapath controls asserted; illegal_op pulses here.
- EXEC:
  - ADD/INC/NEG/SUB: alu_op set, alu_src=0; → WB.
  - SVPC: alu_src=1, alu_op=100, pc_control=1; → WB.
  - LD/ST/JM: alu_op=001, alu_src=1 (address calc); → MEM.
  - J: jump=1; → FETCH.
  - BRZ: branch=z_flag; → FETCH.
  - BRN: branch=n_flag; → FETCH.
  - NOP/illegal: → FETCH.
- MEM:
  - LD/JM: mem_read=1. ST: mem_write=1.
  - Hold until mem_ready.
  - On mem_ready: LD → WB; ST → FETCH; JM → FETCH with jump_m=1 in that ready cycle.
- WB:
  - reg_write=1 for one cycle; mem_to_reg=1 for LD and SVPC, else 0.
  - → FETCH.
- instr_done pulses in the final cycle of each instruction (the cycle whose next state is FETCH).
- Any control not listed for a state is 0.

## Timing
- All outputs are registered and reflect the current state plus the latched op. No combinational path from opcode, z_flag or n_flag to outputs except through flops.
- Reset (synchronous):
  - State → FETCH, op register → NOP.
  - All outputs 0 in the cycle after reset is sampled.
  - fetch_en rises one cycle after reset deasserts.
  - Reset mid-MEM drops mem_read/mem_write the next cycle; no writeback occurs.
- Latency with mem_ready tied high:
  - NOP/J/BRZ/BRN/illegal: 3 cycles.
  - ALU ops, SVPC, ST, JM: 4 cycles.
  - LD: 5 cycles.
  - Each mem_ready wait cycle adds 1 cycle.
- mem_ready is ignored outside FETCH/MEM.
- mem_read/mem_write and fetch_en stay stable high until the handshake completes.
- Flags are sampled only in the EXEC cycle; flag changes in other cycles have no effect.

## Structure
- Package multicycle_pkg:
  - state enum (FETCH, DECODE, EXEC, MEM, WB)
  - opcode localparams
  - alu_op localparams
- One sub-module is natural: op_decoder, a combinational op → per-phase control vector, instantiated once and feeding the output flops.
- The FSM stays in the top module.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 in first post-reset cycle; fetch_en=1 on the next.
- ADD (0100), mem_ready=1 → ir_load/pc_inc in cycle 1, alu_op=001 in cycle 3, reg_write=1 in cycle 4, instr_done in cycle 4.
- LD (1110) with mem_ready low 2 cycles in MEM → mem_read high 3 cycles, then WB with reg_write=1 and mem_to_reg=1; total 7 cycles.
- BRZ (1001) with z_flag=1, then with z_flag=0 → branch=1 in EXEC and 0 respectively; both 3 cycles; z_flag toggled during DECODE has no effect.
- SVPC (1111) → EXEC shows alu_src=1, alu_op=100, pc_control=1; WB shows reg_write=1, mem_to_reg=1.
- Opcode 1100 → illegal_op pulse in DECODE, no datapath control asserted, back to FETCH after 3 cycles. Reset asserted during ST's MEM → mem_write=0 next cycle, state FETCH.
